// File: rtl/reg_access_ctrl_if.sv
// Bus bundle between the register-access controller, the register file, the decoder
// and the execute unit.
`timescale 1ns/1ps
interface reg_access_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_rs1;
  logic [ADDR_W-1:0] req_rs2;
  logic [ADDR_W-1:0] req_rd;
  logic              req_wb;
  logic [ADDR_W-1:0] rsrc1;
  logic [ADDR_W-1:0] rsrc2;
  logic [ADDR_W-1:0] rdst;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rf_out1;
  logic [DATA_W-1:0] rf_out2;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [15:0]       retire_cnt;

  // Controller side.
  modport master (
    input  req_valid, req_rs1, req_rs2, req_rd, req_wb, rf_out1, rf_out2,
    input  op_ready, res_valid, res_data,
    output req_ready, rsrc1, rsrc2, rdst, read, write, wdata,
    output op_valid, op_a, op_b, retire_cnt
  );

  // Decoder / register file / execute-unit side.
  modport slave (
    output req_valid, req_rs1, req_rs2, req_rd, req_wb, rf_out1, rf_out2,
    output op_ready, res_valid, res_data,
    input  req_ready, rsrc1, rsrc2, rdst, read, write, wdata,
    input  op_valid, op_a, op_b, retire_cnt
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// Sequences one instruction at a time: operand read, issue, result wait, write-back.
// Retired instructions are counted in a wrapping 16-bit counter.
`timescale 1ns/1ps
module reg_access_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic                clk,
  input logic                reset,
  reg_access_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StIssue,
    StWaitRes,
    StWrite
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              wb_q, wb_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [15:0]       retire_q, retire_d;

  always_comb begin
    state_d  = state_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    wb_d     = wb_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    wdata_d  = wdata_q;
    retire_d = retire_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          rs1_d   = bus.req_rs1;
          rs2_d   = bus.req_rs2;
          rd_d    = bus.req_rd;
          wb_d    = bus.req_wb;
          state_d = StRead;
        end
      end
      StRead: begin
        op_a_d  = bus.rf_out1;
        op_b_d  = bus.rf_out2;
        state_d = StIssue;
      end
      StIssue: begin
        if (bus.op_ready) state_d = StWaitRes;
      end
      StWaitRes: begin
        if (bus.res_valid) begin
          wdata_d = bus.res_data;
          // Write-backs to register 0 are dropped but the instruction still retires.
          if (wb_q && (rd_q != '0)) begin
            state_d = StWrite;
          end else begin
            state_d  = StIdle;
            retire_d = retire_q + 16'd1;
          end
        end
      end
      StWrite: begin
        state_d  = StIdle;
        retire_d = retire_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      wdata_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      wb_q     <= wb_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
    end
  end

  // The register file treats read=0 as a write, so read idles high.
  assign bus.req_ready  = (state_q == StIdle);
  assign bus.op_valid   = (state_q == StIssue);
  assign bus.write      = (state_q == StWrite);
  assign bus.read       = ~bus.write;
  assign bus.rsrc1      = rs1_q;
  assign bus.rsrc2      = rs2_q;
  assign bus.rdst       = rd_q;
  assign bus.wdata      = wdata_q;
  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Randomized bench for reg_access_ctrl against a transaction-level model of the
// register file, operand handoff and retire count.
`timescale 1ns/1ps
module tb_reg_access_ctrl;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic clk = 1'b0;
  logic reset;
  logic load_en;
  always #5 clk = ~clk;

  reg_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] rf     [32];  // register file seen by the DUT
  logic [31:0] mdl_rf [32];  // expected register contents
  logic [15:0] mdl_cnt;
  int          errors = 0;
  int          checks = 0;
  int          wr_seen = 0;

  assign bus.rf_out1 = rf[bus.rsrc1];
  assign bus.rf_out2 = rf[bus.rsrc2];

  always @(posedge clk) begin
    if (load_en) rf <= mdl_rf;
    else if (!bus.read && bus.rdst != 0) rf[bus.rdst] <= bus.wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check_eq("read_eq_not_write", 32'(bus.read), 32'(!bus.write));
      if (bus.write) begin
        wr_seen++;
        check_eq("write_rd_nonzero", 32'(bus.rdst != 0), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic wb, input logic [31:0] res,
                        input int issue_wait, input int res_wait);
    logic        exp_wr;
    logic [31:0] ea, eb;
    int          w0;
    exp_wr = wb && (rd != 0);
    ea     = mdl_rf[rs1];
    eb     = mdl_rf[rs2];
    w0     = wr_seen;
    check_eq("idle_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_rd    = rd;
    bus.req_wb    = wb;
    tick();
    bus.req_valid = 1'b0;
    bus.req_rs1   = 5'($urandom);
    bus.req_rs2   = 5'($urandom);
    bus.req_rd    = 5'($urandom);
    bus.req_wb    = 1'($urandom);
    check_eq("read_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rsrc1", 32'(bus.rsrc1), 32'(rs1));
    check_eq("rsrc2", 32'(bus.rsrc2), 32'(rs2));
    check_eq("read_op_valid", 32'(bus.op_valid), 32'd0);
    tick();
    check_eq("issue_op_valid", 32'(bus.op_valid), 32'd1);
    check_eq("op_a", bus.op_a, ea);
    check_eq("op_b", bus.op_b, eb);
    for (int i = 0; i < issue_wait; i++) begin
      bus.res_valid = 1'b1;  // must be ignored outside WAIT_RES
      bus.res_data  = $urandom;
      tick();
      bus.res_valid = 1'b0;
      check_eq("stall_op_valid", 32'(bus.op_valid), 32'd1);
      check_eq("stall_op_a", bus.op_a, ea);
      check_eq("stall_op_b", bus.op_b, eb);
      check_eq("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    check_eq("issue_exit", 32'(bus.op_valid), 32'd0);
    for (int i = 0; i < res_wait; i++) begin
      bus.op_ready = 1'b1;  // must be ignored outside ISSUE
      tick();
      bus.op_ready = 1'b0;
      check_eq("wait_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.res_valid = 1'b1;
    bus.res_data  = res;
    tick();
    bus.res_valid = 1'b0;
    bus.res_data  = $urandom;
    if (exp_wr) begin
      check_eq("write_strobe", 32'(bus.write), 32'd1);
      check_eq("rdst", 32'(bus.rdst), 32'(rd));
      check_eq("wdata", bus.wdata, res);
      mdl_rf[rd] = res;
      tick();
    end
    mdl_cnt = mdl_cnt + 16'd1;
    check_eq("retire_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("retire_cnt", 32'(bus.retire_cnt), 32'(mdl_cnt));
    check_eq("retire_write_low", 32'(bus.write), 32'd0);
    check_eq("retire_wdata", bus.wdata, res);
    check_eq("write_count", 32'(wr_seen - w0), 32'(exp_wr));
  endtask

  initial begin
    int accepts, last, cyc, w0;
    reset         = 1'b1;
    load_en       = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_rd    = '0;
    bus.req_wb    = 1'b0;
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    for (int i = 0; i < 32; i++) mdl_rf[i] = $urandom;
    mdl_rf[1] = 32'd7;
    mdl_rf[2] = 32'd3;
    mdl_cnt   = '0;
    repeat (2) tick();
    reset   = 1'b0;
    load_en = 1'b0;

    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_op_valid", 32'(bus.op_valid), 32'd0);
    check_eq("rst_write", 32'(bus.write), 32'd0);
    check_eq("rst_read", 32'(bus.read), 32'd1);
    check_eq("rst_rsrc1", 32'(bus.rsrc1), 32'd0);
    check_eq("rst_rsrc2", 32'(bus.rsrc2), 32'd0);
    check_eq("rst_rdst", 32'(bus.rdst), 32'd0);
    check_eq("rst_wdata", bus.wdata, 32'd0);
    check_eq("rst_op_a", bus.op_a, 32'd0);
    check_eq("rst_op_b", bus.op_b, 32'd0);
    check_eq("rst_retire", 32'(bus.retire_cnt), 32'd0);

    // Basic op, then a dropped write-back to r0, then backpressure.
    run_op(5'd1, 5'd2, 5'd4, 1'b1, 32'd10, 0, 0);
    run_op(5'd3, 5'd1, 5'd0, 1'b1, 32'd5, 0, 1);
    run_op(5'd4, 5'd2, 5'd9, 1'b1, 32'hCAFE_F00D, 5, 2);

    for (int n = 0; n < 30; n++) begin
      run_op(5'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Back-to-back: request and handshakes held high continuously.
    w0 = wr_seen;
    bus.req_valid = 1'b1;
    bus.req_rs1   = 5'd3;
    bus.req_rs2   = 5'd4;
    bus.req_rd    = 5'd6;
    bus.req_wb    = 1'b1;
    bus.op_ready  = 1'b1;
    bus.res_valid = 1'b1;
    bus.res_data  = 32'h1234_5678;
    accepts = 0;
    last    = -1;
    cyc     = 0;
    while (accepts < 3 && cyc < 40) begin
      if (bus.req_ready) begin
        accepts++;
        if (last >= 0) check_eq("b2b_gap", 32'(cyc - last), 32'd5);
        last = cyc;
      end
      tick();
      cyc++;
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.req_ready; i++) tick();
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b0;
    mdl_cnt    = mdl_cnt + 16'd3;
    mdl_rf[6]  = 32'h1234_5678;
    check_eq("b2b_accepts", 32'(accepts), 32'd3);
    check_eq("b2b_idle", 32'(bus.req_ready), 32'd1);
    check_eq("b2b_retire", 32'(bus.retire_cnt), 32'(mdl_cnt));
    check_eq("b2b_writes", 32'(wr_seen - w0), 32'd3);
    run_op(5'd6, 5'd6, 5'd7, 1'b1, 32'd42, 0, 0);

    // Reset while waiting for a result.
    bus.req_valid = 1'b1;
    bus.req_rs1   = 5'd1;
    bus.req_rs2   = 5'd2;
    bus.req_rd    = 5'd7;
    bus.req_wb    = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    check_eq("midop_busy", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    mdl_cnt = '0;
    check_eq("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("midrst_write", 32'(bus.write), 32'd0);
    check_eq("midrst_retire", 32'(bus.retire_cnt), 32'd0);
    check_eq("midrst_op_valid", 32'(bus.op_valid), 32'd0);
    check_eq("midrst_wdata", bus.wdata, 32'd0);
    check_eq("midrst_op_a", bus.op_a, 32'd0);
    w0 = wr_seen;
    bus.res_valid = 1'b1;
    bus.res_data  = 32'hDEAD_BEEF;
    tick();
    bus.res_valid = 1'b0;
    check_eq("late_res_idle", 32'(bus.req_ready), 32'd1);
    tick();
    check_eq("late_res_no_write", 32'(wr_seen - w0), 32'd0);
    check_eq("late_res_retire", 32'(bus.retire_cnt), 32'd0);
    run_op(5'd7, 5'd1, 5'd8, 1'b1, 32'd99, 1, 0);

    // Counter wrap: preload the retire count just below the wrap point.
    force dut.retire_q = 16'hFFFF;
    tick();
    release dut.retire_q;
    mdl_cnt = 16'hFFFF;
    check_eq("wrap_preload", 32'(bus.retire_cnt), 32'hFFFF);
    run_op(5'd2, 5'd3, 5'd0, 1'b0, 32'd1, 0, 0);
    check_eq("wrap_zero", 32'(bus.retire_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and operand data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width (32 registers).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req_valid, input, 1 bit: decoded instruction request present.
REQ-006 Port req_ready, output, 1 bit: controller can accept a request.
REQ-007 Ports req_rs1, req_rs2, req_rd, inputs, ADDR_W each: source and destination indices.
REQ-008 Port req_wb, input, 1 bit: the instruction writes back a result.
REQ-009 Ports rsrc1, rsrc2, rdst, outputs, ADDR_W each: register file addresses.
REQ-010 Ports read and write, outputs, 1 bit each: register file read strobe and write strobe.
REQ-011 Port wdata, output, DATA_W: register file write data.
REQ-012 Ports rf_out1 and rf_out2, inputs, DATA_W each: register file read data; combinational from rsrc1/rsrc2.
REQ-013 Ports op_valid (output, 1), op_ready (input, 1), op_a and op_b (outputs, DATA_W): operand handoff to the execute unit.
REQ-014 Ports res_valid (input, 1) and res_data (input, DATA_W): result return from the execute unit.
REQ-015 Port retire_cnt, output, 16 bits: count of completed instructions.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, ISSUE, WAIT_RES and WRITE.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready at a clock edge.
REQ-018 On acceptance, req_rs1, req_rs2, req_rd and req_wb SHALL be latched internally, and the state SHALL go IDLE->READ.
REQ-019 In READ, rsrc1/rsrc2 SHALL drive the latched sources; at the edge, rf_out1/rf_out2 SHALL be captured into op_a/op_b, and the state SHALL go READ->ISSUE.
REQ-020 In ISSUE, op_valid SHALL be 1 and op_a/op_b SHALL be stable; on op_ready the state SHALL go ISSUE->WAIT_RES.
REQ-021 In WAIT_RES, on res_valid the controller SHALL latch res_data into wdata. If the latched wb=1 and rd!=0 the state SHALL go to WRITE; otherwise it SHALL go to IDLE and retire.
REQ-022 In WRITE, write SHALL be 1 for exactly one cycle with rdst = latched rd; the state SHALL then go to IDLE and retire.
REQ-023 Register 0 SHALL never be written; a write-back to rd=0 SHALL be dropped silently but the instruction SHALL still retire.
REQ-024 read SHALL equal ~write in every cycle; the register file treats read=0 as a write, so read idles high.
REQ-025 res_valid outside WAIT_RES and op_ready outside ISSUE SHALL be ignored.
REQ-026 retire_cnt SHALL increment by 1 on each retire edge and wrap from 16'hFFFF to 0.
REQ-027 Minimum latency SHALL be: accept at edge 0, op_valid high in cycle 2, write strobe in the cycle after res_valid is sampled.
REQ-028 A new request SHALL be accepted no earlier than the cycle after the return to IDLE; at most one instruction is in flight.

Reset
REQ-029 While reset=1 at a clock edge, the state SHALL become IDLE regardless of the current state, including mid-operation.
REQ-030 After reset, outputs SHALL be: req_ready=1, op_valid=0, write=0, read=1, rsrc1=rsrc2=rdst=0, wdata=0, op_a=op_b=0, retire_cnt=0.
REQ-031 Any in-flight instruction SHALL be abandoned by reset with no write strobe and no retire.

Verification
REQ-032 Basic op: r1=7, r2=3, request rs1=1, rs2=2, rd=4, wb=1; return res_data=10 -> op_a=7 and op_b=3 in cycle 2; one write strobe with rdst=4, wdata=10; retire_cnt=1.
REQ-033 rd=0 with wb=1 and res_data=5 -> write never asserted; read stays 1; retire_cnt increments.
REQ-034 Backpressure: op_ready held low 5 cycles -> op_valid stays 1 with operands unchanged and req_ready=0 throughout; ISSUE exits on the first cycle op_ready=1.
REQ-035 Reset asserted in WAIT_RES -> next cycle IDLE, write=0, retire_cnt=0; a late res_valid afterwards causes no write.
REQ-036 Back-to-back: req_valid held high for 3 requests -> each is accepted only in IDLE; retire_cnt=3; read==~write holds every cycle.
REQ-037 Wrap: retire_cnt at 16'hFFFF plus one retire -> retire_cnt=0.
